// File: rtl/reg_hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks GPR results that cannot be forwarded yet
// and the pending CP0 write, and raises a same-cycle stall on a read of a busy register.
module reg_hazard_scoreboard #(
  parameter int LAT_W  = 3,
  parameter int CP_LAT = 2,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             reg_read_en_1,
  input  logic [4:0]       reg_addr_1,
  input  logic             reg_read_en_2,
  input  logic [4:0]       reg_addr_2,
  input  logic             reg_write_en,
  input  logic [4:0]       reg_write_addr,
  input  logic [LAT_W-1:0] wr_latency,
  input  logic             cp_read_en,
  input  logic [4:0]       cp_read_addr,
  input  logic             cp_write_en,
  input  logic [4:0]       cp_write_addr,
  input  logic             flush,
  output logic             stall_req,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] stall_count
);

  function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
    return (v != '0) ? v - LAT_W'(1) : '0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [LAT_W-1:0] cnt_q [32];
  logic [LAT_W-1:0] cnt_d [32];
  logic [LAT_W-1:0] cp_cnt_q, cp_cnt_d;
  logic [4:0]       cp_addr_q, cp_addr_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic hz_rd1, hz_rd2, hz_cp_rd, hz_cp_wr;
  logic accept;
  logic [LAT_W-1:0] dec;

  // Enables gate each term first so unused (possibly X) addresses never reach the result.
  always_comb begin
    hz_rd1    = reg_read_en_1 && (reg_addr_1 != 5'd0) && (cnt_q[reg_addr_1] != '0);
    hz_rd2    = reg_read_en_2 && (reg_addr_2 != 5'd0) && (cnt_q[reg_addr_2] != '0);
    hz_cp_rd  = cp_read_en && (cp_cnt_q != '0) && (cp_addr_q == cp_read_addr);
    hz_cp_wr  = cp_write_en && (cp_cnt_q != '0);
    stall_req = id_valid && !flush && (hz_rd1 || hz_rd2 || hz_cp_rd || hz_cp_wr);
    accept    = id_valid && !stall_req && !flush;
  end

  // A new write never shortens an older, longer one still in flight (WAW).
  always_comb begin
    dec      = '0;
    cnt_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      dec = sat_dec(cnt_q[r]);
      if (flush) begin
        cnt_d[r] = '0;
      end else if (accept && reg_write_en && (reg_write_addr == 5'(r)) &&
                   (wr_latency != '0)) begin
        cnt_d[r] = (wr_latency > dec) ? wr_latency : dec;
      end else begin
        cnt_d[r] = dec;
      end
    end
  end

  always_comb begin
    cp_cnt_d  = sat_dec(cp_cnt_q);
    cp_addr_d = cp_addr_q;
    if (flush) begin
      cp_cnt_d = '0;
    end else if (accept && cp_write_en) begin
      cp_cnt_d  = LAT_W'(CP_LAT);
      cp_addr_d = cp_write_addr;
    end
    stall_count_d = stall_req ? sat_inc(stall_count_q) : stall_count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      cp_cnt_q      <= '0;
      cp_addr_q     <= '0;
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      cp_cnt_q      <= cp_cnt_d;
      cp_addr_q     <= cp_addr_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < 32; r++) busy_mask[r] = (cnt_q[r] != '0);
  end

  assign stall_count = stall_count_q;

endmodule
